// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes IF-stage fetches and MEM-stage loads/stores onto one fixed-latency
// memory port; data accesses take priority because they belong to the older instruction.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LatCnt = CW'(MEM_LAT);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   dm_rdata_q;
    logic          if_ack_q;
    logic          dm_ack_q;
    logic          dm_load_q;

    // Masking with the ack stops a request held through its ack cycle from being regranted.
    logic dq;
    logic iq;
    assign dq = bus.dm_req & ~dm_ack_q;
    assign iq = bus.if_req & ~if_ack_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            dm_load_q   <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (dq) begin
                        state_q     <= StBusyDm;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        dm_load_q   <= ~bus.dm_we;
                        cnt_q       <= '0;
                    end else if (iq) begin
                        state_q    <= StBusyIf;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        cnt_q      <= '0;
                    end
                end
                StBusyIf: begin
                    if (cnt_q == LatCnt) begin
                        state_q    <= StIdle;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bus.mem_rdata;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBusyDm: begin
                    if (cnt_q == LatCnt) begin
                        state_q  <= StIdle;
                        dm_ack_q <= 1'b1;
                        if (dm_load_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.dm_req & ~dm_ack_q;
endmodule
